// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small circular byte FIFO feeding a
// START/DATA/STOP/CLEANUP serialiser with registered line and ready outputs.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic       o_Overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
    localparam logic [11:0] LastClk = 12'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StStop    = 3'd3,
        StCleanup = 3'd4
    } state_e;

    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            ovf_q, ovf_d;
    logic            serial_q, serial_d;
    state_e          state_q, state_d;
    logic [11:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push;
    logic            pop;

    // Writes are gated by the registered ready, so a full FIFO drops them even if it pops now.
    assign push = i_Tx_DV && ready_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < FullCount);
        ovf_d   = i_Tx_DV && !ready_q;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                clk_cnt_d = 12'd0;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == LastClk) begin
                    clk_cnt_d = 12'd0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
            end
            StData: begin
                if (clk_cnt_q == LastClk) begin
                    clk_cnt_d = 12'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
            end
            StStop: begin
                if (clk_cnt_q == LastClk) begin
                    clk_cnt_d = 12'd0;
                    state_d   = StCleanup;
                end else begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
            end
            StCleanup: begin
                clk_cnt_d = 12'd0;
                state_d   = StIdle;
            end
            default: begin
                clk_cnt_d = 12'd0;
                state_d   = StIdle;
            end
        endcase

        // Line level follows the next state so it is registered alongside it.
        case (state_d)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            ovf_q     <= 1'b0;
            serial_q  <= 1'b1;
            state_q   <= StIdle;
            clk_cnt_q <= 12'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            serial_q  <= serial_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    assign o_Tx_Ready  = ready_q;
    assign o_Tx_Serial = serial_q;
    assign o_Overflow  = ovf_q;
    assign o_Tx_Active = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign o_Tx_Done   = (state_q == StStop) && (clk_cnt_q == LastClk);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues expected bytes and checks,
// a single monitor process decodes the line as an 8N1 receiver and compares.
module tb_uart_tx_buffered;

    localparam int Cpb = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] din = 8'd0;
    logic       tx_ready, tx_serial, tx_active, tx_done, ovf;

    uart_tx_buffered #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Tx_DV    (dv),
        .i_Tx_Byte  (din),
        .o_Tx_Ready (tx_ready),
        .o_Tx_Serial(tx_serial),
        .o_Tx_Active(tx_active),
        .o_Tx_Done  (tx_done),
        .o_Overflow (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    act;
        int    req;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] exp_q[$];
    int         edges[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_frames = 0;
    int         done_cnt = 0;
    int         active_cnt = 0;
    int         ovf_cnt = 0;
    int         rdy_low_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        done_cnt    <= done_cnt + int'(tx_done);
        active_cnt  <= active_cnt + int'(tx_active);
        ovf_cnt     <= ovf_cnt + int'(ovf);
        rdy_low_cnt <= rdy_low_cnt + int'(!tx_ready);
    end

    function automatic void chk(string name, int act, int req);
        chk_q.push_back('{name: name, act: act, req: req});
    endfunction

    // Monitor: drains queued checks and decodes frames, sampling mid-bit.
    initial begin
        chk_t       c;
        logic [7:0] eb;
        logic [9:0] rx_bits;
        logic       rx_busy;
        logic       prev_ser;
        int         rx_cnt;
        rx_bits  = '0;
        rx_busy  = 1'b0;
        prev_ser = 1'b1;
        rx_cnt   = 0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_cmp++;
                if (c.act != c.req) begin
                    n_err++;
                    $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.req);
                end
            end
            if (rst) begin
                rx_busy  = 1'b0;
                prev_ser = 1'b1;
            end else begin
                if (!rx_busy) begin
                    if (prev_ser && !tx_serial) begin
                        rx_busy = 1'b1;
                        rx_cnt  = 0;
                        edges.push_back(cyc);
                    end
                end else begin
                    rx_cnt++;
                    if (rx_cnt % Cpb == Cpb / 2) begin
                        rx_bits[rx_cnt / Cpb] = tx_serial;
                        if (rx_cnt / Cpb == 9) begin
                            rx_busy = 1'b0;
                            n_frames++;
                            n_cmp++;
                            if (exp_q.size() == 0) begin
                                n_err++;
                                $display("FAIL frame: got 0x%02h with no byte expected",
                                         rx_bits[8:1]);
                            end else begin
                                eb = exp_q.pop_front();
                                if (rx_bits != {1'b1, eb, 1'b0}) begin
                                    n_err++;
                                    $display("FAIL frame: got bits %b, expected %b",
                                             rx_bits, {1'b1, eb, 1'b0});
                                end
                            end
                        end
                    end
                end
                prev_ser = tx_serial;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || tx_active) && t < budget);
        chk("drain", exp_q.size(), 0);
        chk("idle_wait", int'(tx_active), 0);
    endtask

    task automatic push_when_ready(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", int'(t < 500), 1);
        exp_q.push_back(b);
        dv  = 1'b1;
        din = b;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [4];
        logic [7:0] ovb [6];
        int d0, a0, o0, r0, f0, e0, acc;
        b2b = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        ovb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        repeat (3) @(negedge clk);
        chk("rst_serial", int'(tx_serial), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_active", int'(tx_active), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_overflow", int'(ovf), 0);

        // Single byte, written on the first edge after reset release.
        d0 = done_cnt;
        a0 = active_cnt;
        e0 = edges.size();
        exp_q.push_back(8'hA5);
        rst = 1'b0;
        dv  = 1'b1;
        din = 8'hA5;
        @(negedge clk);
        acc = cyc;
        dv  = 1'b0;
        wait_idle(300);
        chk("single_done", done_cnt - d0, 1);
        chk("single_active", active_cnt - a0, 80);
        chk("single_edges", edges.size() - e0, 1);
        chk("single_latency", edges[edges.size() - 1] - acc, 1);

        // Back-to-back frames.
        d0 = done_cnt;
        r0 = rdy_low_cnt;
        e0 = edges.size();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(b2b[i]);
            dv  = 1'b1;
            din = b2b[i];
            @(negedge clk);
        end
        dv = 1'b0;
        wait_idle(600);
        chk("b2b_done", done_cnt - d0, 4);
        chk("b2b_ready_low", rdy_low_cnt - r0, 0);
        chk("b2b_edges", edges.size() - e0, 4);
        for (int i = 1; i < 4; i++) begin
            chk("b2b_spacing", edges[e0 + i] - edges[e0 + i - 1], 82);
        end

        // Fill and overflow: the 6th write is dropped.
        d0 = done_cnt;
        o0 = ovf_cnt;
        f0 = n_frames;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(ovb[i]);
            dv  = 1'b1;
            din = ovb[i];
            @(negedge clk);
            if (i == 3) chk("ready_before_full", int'(tx_ready), 1);
            if (i == 4) chk("ready_full", int'(tx_ready), 0);
            if (i == 5) chk("overflow_pulse", int'(ovf), 1);
        end
        dv = 1'b0;
        @(negedge clk);
        chk("overflow_clear", int'(ovf), 0);
        wait_idle(1000);
        chk("ovf_done", done_cnt - d0, 5);
        chk("ovf_count", ovf_cnt - o0, 1);
        chk("ovf_frames", n_frames - f0, 5);
        chk("ovf_ready_back", int'(tx_ready), 1);

        // Wrap-around at ready pace.
        f0 = n_frames;
        for (int i = 1; i <= 12; i++) begin
            push_when_ready(8'(i));
        end
        wait_idle(2000);
        chk("wrap_frames", n_frames - f0, 12);

        // Reset during bit 3 of 0x0F with two bytes queued; nothing may complete.
        d0 = done_cnt;
        f0 = n_frames;
        e0 = edges.size();
        dv  = 1'b1;
        din = 8'h0F;
        @(negedge clk);
        din = 8'hAA;
        @(negedge clk);
        din = 8'h55;
        @(negedge clk);
        dv = 1'b0;
        repeat (33) @(negedge clk);
        chk("mid_active", int'(tx_active), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_serial", int'(tx_serial), 1);
        chk("abort_ready", int'(tx_ready), 1);
        chk("abort_active", int'(tx_active), 0);
        chk("abort_done", int'(tx_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_frames", n_frames - f0, 0);
        chk("abort_no_new_start", edges.size() - e0, 1);
        chk("abort_idle_line", int'(tx_serial), 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (100 MHz, 115200 baud); legal range 4..4096.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte-FIFO depth; power of two, 2..16.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_Tx_DV, input, 1 bit: write strobe; byte accepted on any rising edge where i_Tx_DV=1 and o_Tx_Ready=1.
REQ-006 SHALL have port i_Tx_Byte, input, 8 bits: byte to transmit, sampled with i_Tx_DV.
REQ-007 SHALL have port o_Tx_Ready, output, 1 bit: FIFO not full, registered.
REQ-008 SHALL have port o_Tx_Serial, output, 1 bit: serial line, 8N1, idle high, registered.
REQ-009 SHALL have port o_Tx_Active, output, 1 bit: high in START, DATA and STOP states.
REQ-010 SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse at the end of each stop bit.
REQ-011 SHALL have port o_Overflow, output, 1 bit: one-cycle pulse when i_Tx_DV=1 while o_Tx_Ready=0.

Function
REQ-012 SHALL buffer bytes in a FIFO_DEPTH-entry circular FIFO; pointers wrap modulo FIFO_DEPTH; occupancy count holds 0..FIFO_DEPTH.
REQ-013 SHALL drop a write while full: FIFO contents unchanged, o_Overflow=1 on the next cycle. This applies even if a pop occurs in the same cycle.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, CLEANUP; any illegal encoding SHALL go to IDLE.
REQ-015 SHALL, in IDLE with count>0, pop the head byte into an 8-bit shift register, clear the bit counter and go to START. A byte pushed into an empty FIFO is popped no earlier than the following cycle.
REQ-016 SHALL drive o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles in START, beginning the cycle START is entered.
REQ-017 SHALL, in DATA, send 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; bit index 0..7, then go to STOP.
REQ-018 SHALL drive o_Tx_Serial=1 for exactly CLKS_PER_BIT cycles in STOP, pulse o_Tx_Done on the last STOP cycle, then go to CLEANUP.
REQ-019 SHALL spend exactly 1 cycle in CLEANUP with o_Tx_Serial=1, then go to IDLE.
REQ-020 SHALL hold o_Tx_Serial=1 in IDLE and CLEANUP. Back-to-back frames SHALL therefore have exactly 10*CLKS_PER_BIT+2 cycles between start-bit falling edges.
REQ-021 SHALL use a clock counter that counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit transition; it is 12 bits wide.
REQ-022 SHALL allow push and pop in the same cycle when 0<count<FIFO_DEPTH, leaving count unchanged.
REQ-023 SHALL keep o_Tx_Ready=(count<FIFO_DEPTH) updated one cycle after the push or pop that changes count.
REQ-024 SHALL not alter a frame in progress because of writes, overflows or a FIFO becoming full or empty.

Reset
REQ-025 SHALL, on i_Reset=1 and regardless of clock, force: state IDLE, FIFO empty (pointers and count 0), counters 0, o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0.
REQ-026 SHALL abort a frame in progress when reset is asserted mid-frame: line high immediately, buffered bytes discarded, no o_Tx_Done pulse.
REQ-027 SHALL start first-edge operation cleanly after reset deassertion; i_Tx_DV on the first post-reset edge is accepted.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-028 Single byte: write 0xA5 once -> line low 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, high 8 cycles; o_Tx_Done pulses once; o_Tx_Active high 80 cycles.
REQ-029 Back-to-back: write 0x00, 0xFF, 0x55, 0x3C on consecutive cycles -> four correct frames, start edges 82 cycles apart, o_Tx_Ready never low, 4 o_Tx_Done pulses.
REQ-030 Full/overflow: write 6 bytes consecutively while the first is transmitting -> o_Tx_Ready low after the FIFO fills; the 6th write raises o_Overflow for 1 cycle and is dropped; exactly 5 frames are sent.
REQ-031 Reset mid-frame: assert i_Reset during bit 3 of 0x0F with 2 bytes queued -> o_Tx_Serial=1 asynchronously, o_Tx_Ready=1, no further frames, no o_Tx_Done.
REQ-032 Wrap-around: 12 sequential bytes 0x01..0x0C written at o_Tx_Ready pace -> all received in order by a reference 8N1 receiver model.
